// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit basic processor: opcodes, sequencer states, control word.
// SEQUENCER_HALT_EN adds the HALT state for undefined opcodes.
package cpu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned WORD_W = 8;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_BNE   = 3'b100
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH0,
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_EXEC0,
        S_EXEC1
`ifdef SEQUENCER_HALT_EN
        , S_HALT
`endif
    } state_t;

    // One bit per control line driven by the sequencer.
    typedef struct packed {
        logic acc_bus;
        logic load_acc;
        logic pc_bus;
        logic load_pc;
        logic inc_pc;
        logic load_ir;
        logic load_mar;
        logic mdr_bus;
        logic load_mdr;
        logic alu_acc;
        logic alu_add;
        logic alu_sub;
        logic addr_bus;
        logic cs;
        logic r_nw;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/sequencer.sv
// Moore control sequencer: fetch / decode / execute for the 8-bit basic processor.
// Build with SEQUENCER_HALT_EN to trap undefined opcodes in HALT instead of skipping them.
module sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned OP_W = cpu_pkg::OP_W
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            Addr_bus,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);

    state_t state_q, state_d;
    ctrl_t  ctrl_c;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) state_q <= S_FETCH0;
        else          state_q <= state_d;
    end

    // Next-state: opcode only matters once the IR is valid, from DECODE onward.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_W'(OP_LOAD), OP_W'(OP_STORE),
                    OP_W'(OP_ADD),  OP_W'(OP_SUB):  state_d = S_EXEC0;
                    OP_W'(OP_BNE):                  state_d = S_FETCH0;
`ifdef SEQUENCER_HALT_EN
                    default:                        state_d = S_HALT;
`else
                    default:                        state_d = S_FETCH0;
`endif
                endcase
            end
            S_EXEC0: state_d = S_EXEC1;
            S_EXEC1: state_d = S_FETCH0;
`ifdef SEQUENCER_HALT_EN
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_FETCH0;
        endcase
    end

    // Output decode; reset overrides everything, including the idle-high R_NW.
    always_comb begin
        ctrl_c      = '0;
        ctrl_c.r_nw = 1'b1;
        case (state_q)
            S_FETCH0: begin
                ctrl_c.pc_bus   = 1'b1;
                ctrl_c.load_mar = 1'b1;
                ctrl_c.inc_pc   = 1'b1;
                ctrl_c.load_pc  = 1'b1;
            end
            S_FETCH1: ctrl_c.cs = 1'b1;
            S_FETCH2: begin
                ctrl_c.mdr_bus = 1'b1;
                ctrl_c.load_ir = 1'b1;
            end
            S_DECODE: begin
                case (op)
                    OP_W'(OP_BNE): begin
                        if (!z_flag) begin
                            ctrl_c.addr_bus = 1'b1;
                            ctrl_c.load_pc  = 1'b1;
                        end
                    end
                    OP_W'(OP_LOAD), OP_W'(OP_STORE),
                    OP_W'(OP_ADD),  OP_W'(OP_SUB): begin
                        ctrl_c.addr_bus = 1'b1;
                        ctrl_c.load_mar = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC0: begin
                if (op == OP_W'(OP_STORE)) begin
                    ctrl_c.acc_bus  = 1'b1;
                    ctrl_c.load_mdr = 1'b1;
                end else begin
                    ctrl_c.cs = 1'b1;
                end
            end
            S_EXEC1: begin
                case (op)
                    OP_W'(OP_STORE): begin
                        ctrl_c.cs   = 1'b1;
                        ctrl_c.r_nw = 1'b0;
                    end
                    OP_W'(OP_LOAD), OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        ctrl_c.mdr_bus  = 1'b1;
                        ctrl_c.alu_acc  = 1'b1;
                        ctrl_c.load_acc = 1'b1;
                        ctrl_c.alu_add  = (op == OP_W'(OP_ADD));
                        ctrl_c.alu_sub  = (op == OP_W'(OP_SUB));
                    end
                    default: ;
                endcase
            end
`ifdef SEQUENCER_HALT_EN
            S_HALT: ctrl_c.halted = 1'b1;
`endif
            default: ;
        endcase
        if (!n_reset) ctrl_c = '0;
    end

    assign ACC_bus  = ctrl_c.acc_bus;
    assign load_ACC = ctrl_c.load_acc;
    assign PC_bus   = ctrl_c.pc_bus;
    assign load_PC  = ctrl_c.load_pc;
    assign INC_PC   = ctrl_c.inc_pc;
    assign load_IR  = ctrl_c.load_ir;
    assign load_MAR = ctrl_c.load_mar;
    assign MDR_bus  = ctrl_c.mdr_bus;
    assign load_MDR = ctrl_c.load_mdr;
    assign ALU_ACC  = ctrl_c.alu_acc;
    assign ALU_add  = ctrl_c.alu_add;
    assign ALU_sub  = ctrl_c.alu_sub;
    assign Addr_bus = ctrl_c.addr_bus;
    assign CS       = ctrl_c.cs;
    assign R_NW     = ctrl_c.r_nw;
    assign halted   = ctrl_c.halted;

endmodule

// File: doc/sequencer.md
# sequencer

Control sequencer for the 8-bit basic processor. A Moore-style FSM drives every bus-enable, register-load, ALU-select and memory-strobe line: `load_MAR`, `MDR_bus`, `load_MDR`, `CS` and `R_NW` to the ROM/RAM, and the PC, IR, ACC and ALU controls to the datapath. It sits directly upstream of the memory blocks and the datapath, sequencing instruction fetch, decode and execute from the IR opcode and the ALU zero flag.

## Interface
- `OP_W`, default 3: opcode width (top bits of the 8-bit word).
- `clock` input, 1: system clock; all state changes on its rising edge.
- `n_reset` input, 1: reset, asynchronous and active-low.
- `op` input, `OP_W`: opcode field of the IR.
- `z_flag` input, 1: ALU zero flag (ACC == 0).
- `ACC_bus` output, 1: ACC drives the system bus.
- `load_ACC` output, 1: load ACC from the ALU.
- `PC_bus` output, 1: PC drives the system bus.
- `load_PC` output, 1: load the PC.
- `INC_PC` output, 1: PC source is PC+1 (otherwise the bus).
- `load_IR` output, 1: load the IR from the bus.
- `load_MAR` output, 1: memory MAR loads from the bus.
- `MDR_bus` output, 1: memory MDR drives the bus.
- `load_MDR` output, 1: memory MDR loads from the bus.
- `ALU_ACC` output, 1: ALU result is selected into ACC.
- `ALU_add` output, 1: ALU adds.
- `ALU_sub` output, 1: ALU subtracts. With `ALU_ACC`=1 and both add and sub at 0, the ALU passes the bus value.
- `Addr_bus` output, 1: IR address field drives the bus.
- `CS` output, 1: memory chip select.
- `R_NW` output, 1: 1 = read, 0 = write.
- `halted` output, 1: sequencer is in HALT.

## Operation
- Opcodes: LOAD 000, STORE 001, ADD 010, SUB 011, BNE 100. Codes 101–111 are undefined.
- States: FETCH0, FETCH1, FETCH2, DECODE, EXEC0, EXEC1, HALT.
- Outputs are decoded combinationally from state, `op` and `z_flag`. Any output not listed for a state is 0, except `R_NW`, which is 1.
- FETCH0:
  - Outputs: `PC_bus`, `load_MAR`, `INC_PC`, `load_PC`.
  - Next state: FETCH1.
- FETCH1:
  - Outputs: `CS`, `R_NW`=1.
  - Next state: FETCH2.
- FETCH2:
  - Outputs: `MDR_bus`, `load_IR`.
  - Next state: DECODE.
- DECODE, BNE:
  - If `z_flag`=0: `Addr_bus` and `load_PC` (`INC_PC`=0).
  - If `z_flag`=1: no outputs.
  - Next state: FETCH0 in both cases.
- DECODE, LOAD/STORE/ADD/SUB:
  - Outputs: `Addr_bus`, `load_MAR`.
  - Next state: EXEC0.
- DECODE, undefined opcode:
  - Next state: FETCH0, or HALT (see Configuration).
- EXEC0:
  - LOAD/ADD/SUB: `CS`, `R_NW`=1.
  - STORE: `ACC_bus`, `load_MDR`.
  - Next state: EXEC1.
- EXEC1:
  - LOAD: `MDR_bus`, `ALU_ACC`, `load_ACC`.
  - ADD: the LOAD set plus `ALU_add`.
  - SUB: the LOAD set plus `ALU_sub`.
  - STORE: `CS`, `R_NW`=0.
  - Next state: FETCH0.
- HALT: all strobes 0, `halted`=1. Exit only by reset.
- At most one bus driver (`ACC_bus`, `PC_bus`, `MDR_bus`, `Addr_bus`) is asserted in any state.

## Timing
- Instruction length: LOAD/ADD/SUB/STORE take 6 cycles; BNE (taken or not) and undefined opcodes take 4.
- While `n_reset`=0:
  - State is FETCH0.
  - Every output, including `R_NW` and `halted`, is forced to 0.
- After reset:
  - FETCH0 outputs appear in the cycle `n_reset` rises.
  - The first edge with `n_reset`=1 performs FETCH0's loads.
- Reset asserted mid-instruction (any state, including HALT): outputs drop to 0 asynchronously and the instruction is abandoned.
- `op` and `z_flag` are sampled only in DECODE, EXEC0 and EXEC1. Changes outside those states have no effect.
- Memory read latency is one cycle: data is addressed in the `CS` cycle and driven by `MDR_bus` in the next state.

## Configuration
- `SEQUENCER_HALT_EN` defined:
  - An undefined opcode in DECODE moves to HALT.
  - `halted`=1 from the next cycle until reset.
- `SEQUENCER_HALT_EN` undefined:
  - HALT is not compiled.
  - An undefined opcode acts as a NOP (DECODE → FETCH0, no strobes).
  - `halted` is tied to 0.

## Structure
- Shared package `cpu_pkg`: `opcode_t` enum (the five codes), `state_t` enum, `OP_W` and `WORD_W` constants.
- Single module; no sub-module. The next-state logic and the output decode are two `always_comb` blocks beside one `always_ff` state register.

## Test plan
- Reset release: hold `n_reset`=0 → all outputs 0. Release → `PC_bus`, `load_MAR`, `INC_PC`, `load_PC`=1 that cycle, then FETCH1 shows `CS`=1, `R_NW`=1.
- LOAD, `op`=000: DECODE shows `Addr_bus`+`load_MAR`, EXEC0 `CS`/`R_NW`=1, EXEC1 `MDR_bus`+`ALU_ACC`+`load_ACC` with `ALU_add`=`ALU_sub`=0. Back in FETCH0 6 cycles after the previous FETCH0.
- STORE, `op`=001: EXEC0 `ACC_bus`+`load_MDR`, EXEC1 `CS`=1, `R_NW`=0. No cycle has two bus drivers.
- BNE, `op`=100:
  - `z_flag`=0 → DECODE asserts `Addr_bus`+`load_PC` with `INC_PC`=0.
  - `z_flag`=1 → DECODE asserts nothing.
  - Both return to FETCH0 after 4 cycles.
- ADD then SUB back to back: `ALU_add`=1 only in ADD's EXEC1, `ALU_sub`=1 only in SUB's EXEC1. Drop `n_reset` during SUB's EXEC0 → outputs 0 immediately, restart at FETCH0.
- Undefined opcode, `op`=111:
  - Macro defined → `halted`=1 and all strobes 0 for 20+ cycles, cleared only by reset.
  - Macro undefined → FETCH0 follows DECODE.
